// File: rtl/sbox_sram.sv
// Four-bank Blowfish S-box store with a streaming initial-contents load sequencer.
// Optional define SBOX_SRAM_WRITE_READBACK_EN makes port writes also update sN_out (write-through).
module sbox_sram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [$clog2(DEPTH)-1:0]   s1_addr,
  input  logic [WIDTH-1:0]           s1_in,
  input  logic                       s1_cs_l,
  input  logic                       s1_we_l,
  output logic [WIDTH-1:0]           s1_out,
  input  logic [$clog2(DEPTH)-1:0]   s2_addr,
  input  logic [WIDTH-1:0]           s2_in,
  input  logic                       s2_cs_l,
  input  logic                       s2_we_l,
  output logic [WIDTH-1:0]           s2_out,
  input  logic [$clog2(DEPTH)-1:0]   s3_addr,
  input  logic [WIDTH-1:0]           s3_in,
  input  logic                       s3_cs_l,
  input  logic                       s3_we_l,
  output logic [WIDTH-1:0]           s3_out,
  input  logic [$clog2(DEPTH)-1:0]   s4_addr,
  input  logic [WIDTH-1:0]           s4_in,
  input  logic                       s4_cs_l,
  input  logic                       s4_we_l,
  output logic [WIDTH-1:0]           s4_out,
  input  logic                       load_start,
  input  logic                       load_valid,
  input  logic [WIDTH-1:0]           load_data,
  output logic                       load_ready,
  output logic                       load_done,
  output logic                       busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_we;
  logic          port_en;

  logic [3:0][AW-1:0]    p_addr;
  logic [3:0][WIDTH-1:0] p_wdata;
  logic [3:0][WIDTH-1:0] p_rdata;
  logic [3:0]            p_cs_l;
  logic [3:0]            p_we_l;

  assign p_addr  = {s4_addr, s3_addr, s2_addr, s1_addr};
  assign p_wdata = {s4_in, s3_in, s2_in, s1_in};
  assign p_cs_l  = {s4_cs_l, s3_cs_l, s2_cs_l, s1_cs_l};
  assign p_we_l  = {s4_we_l, s3_we_l, s2_we_l, s1_we_l};
  assign s1_out  = p_rdata[0];
  assign s2_out  = p_rdata[1];
  assign s3_out  = p_rdata[2];
  assign s4_out  = p_rdata[3];

  // Initiator ports are locked out only while words are being streamed in.
  assign port_en = (state_q != S_LOAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_ready = 1'b0;
    load_done  = 1'b0;
    busy       = 1'b0;
    load_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        load_ready = 1'b1;
        busy       = 1'b1;
        if (load_valid) begin
          load_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == {CW{1'b1}}) state_d = S_DONE;
        end
      end
      S_DONE: begin
        load_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_bank
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] out_q, out_d;
    logic             sel_load, port_wr, rd_en, wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    // Upper counter bits pick the bank, so stream word k lands in S-box k/DEPTH.
    assign sel_load = load_we && (cnt_q[CW-1:AW] == 2'(gi));
    assign port_wr  = port_en && !p_cs_l[gi] && !p_we_l[gi];
    assign rd_en    = port_en && !p_cs_l[gi] &&  p_we_l[gi];
    assign wr_en    = sel_load || port_wr;
    assign wr_addr  = sel_load ? cnt_q[AW-1:0] : p_addr[gi];
    assign wr_data  = sel_load ? load_data : p_wdata[gi];

    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_comb begin
      out_d = out_q;
      if (rd_en) out_d = mem[p_addr[gi]];
`ifdef SBOX_SRAM_WRITE_READBACK_EN
      else if (port_wr) out_d = p_wdata[gi];
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) out_q <= '0;
      else       out_q <= out_d;
    end

    assign p_rdata[gi] = out_q;
  end

endmodule

// File: tb/tb_sbox_sram.sv
// Randomized scoreboard bench for sbox_sram: reference memory model, queued expected outputs, monitor compares.
module tb_sbox_sram;
`ifdef SBOX_SRAM_WRITE_READBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0][7:0]  addr;
  logic [3:0][31:0] wdata;
  logic [3:0]       cs_l;
  logic [3:0]       we_l;
  logic [3:0][31:0] sout;
  logic             load_start, load_valid;
  logic [31:0]      load_data;
  logic             load_ready, load_done, busy;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0]      ref_mem [4][256];
  logic [3:0][31:0] last_out;
  logic [3:0][31:0] exp_q[$];

  always #5 clk = ~clk;

  sbox_sram dut (
    .clk(clk), .reset(reset),
    .s1_addr(addr[0]), .s1_in(wdata[0]), .s1_cs_l(cs_l[0]), .s1_we_l(we_l[0]), .s1_out(sout[0]),
    .s2_addr(addr[1]), .s2_in(wdata[1]), .s2_cs_l(cs_l[1]), .s2_we_l(we_l[1]), .s2_out(sout[1]),
    .s3_addr(addr[2]), .s3_in(wdata[2]), .s3_cs_l(cs_l[2]), .s3_we_l(we_l[2]), .s3_out(sout[2]),
    .s4_addr(addr[3]), .s4_in(wdata[3]), .s4_cs_l(cs_l[3]), .s4_we_l(we_l[3]), .s4_out(sout[3]),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one queued expectation per issued port cycle, compared just after the edge.
  initial begin
    logic [3:0][31:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        for (int b = 0; b < 4; b++) chk($sformatf("s%0d_out", b + 1), sout[b], e[b]);
      end
    end
  end

  // One port cycle on all four banks; model updates memory and expected outputs.
  task automatic port_op(input logic [3:0] cs_n, input logic [3:0] we_n,
                         input logic [3:0][7:0] a, input logic [3:0][31:0] d);
    cs_l = cs_n; we_l = we_n; addr = a; wdata = d;
    for (int b = 0; b < 4; b++) begin
      if (!cs_n[b]) begin
        if (!we_n[b]) begin
          ref_mem[b][a[b]] = d[b];
          if (WB) last_out[b] = d[b];
        end else begin
          last_out[b] = ref_mem[b][a[b]];
        end
      end
    end
    exp_q.push_back(last_out);
    @(negedge clk);
    cs_l = '1; we_l = '1;
  endtask

  task automatic rand_ops(input int n);
    logic [3:0][7:0]  a;
    logic [3:0][31:0] d;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) a[b] = 8'($urandom_range(0, 7));
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      port_op(4'($urandom()), 4'($urandom()), a, d);
    end
  endtask

  // mode: 0 -> word k, 1 -> ~k, 2 -> random. limit < 1024 stops mid-load.
  task automatic do_load(input int mode, input bit stall, input bit disturb,
                         input int limit, input int exp_cycles, input string tag);
    int k, cycles;
    bit early, v;
    logic [31:0] w;
    logic [3:0][31:0] pre;
    pre = last_out;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    chk({tag, " load_ready"}, 32'(load_ready), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    k = 0; cycles = 0; early = 1'b0;
    while (k < limit && cycles < 5000) begin
      v = stall ? (cycles % 2 == 0) : 1'b1;
      w = (mode == 0) ? 32'(k) : (mode == 1) ? ~32'(k) : $urandom();
      load_valid = v;
      load_data  = w;
      if (disturb) begin
        cs_l = '0; we_l = '0;
        addr = $urandom();
        wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        load_start = (cycles == 100);
      end
      @(negedge clk);
      if (v) begin
        ref_mem[k / 256][k % 256] = w;
        k++;
      end
      cycles++;
      if (k < 1024 && load_done) early = 1'b1;
    end
    load_valid = 1'b0; load_start = 1'b0; cs_l = '1; we_l = '1;
    chk({tag, " words accepted"}, 32'(k), 32'(limit));
    if (limit == 1024) begin
      chk({tag, " cycles to done"}, 32'(cycles), 32'(exp_cycles));
      chk({tag, " load_done"}, 32'(load_done), 32'd1);
      chk({tag, " busy in done"}, 32'(busy), 32'd0);
      chk({tag, " early done"}, 32'(early), 32'd0);
      @(negedge clk);
      chk({tag, " load_done pulse end"}, 32'(load_done), 32'd0);
      for (int b = 0; b < 4; b++)
        chk($sformatf("%s s%0d_out hold", tag, b + 1), sout[b], pre[b]);
    end
    $display("load %s: %0d words, %0d cycles", tag, k, cycles);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a8;
    reset = 1'b1;
    addr = '0; wdata = '0; cs_l = '1; we_l = '1;
    load_start = 1'b0; load_valid = 1'b0; load_data = '0;
    last_out = '0;
    @(negedge clk);
    @(negedge clk);
    for (int b = 0; b < 4; b++) chk($sformatf("reset s%0d_out", b + 1), sout[b], 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset load_ready", 32'(load_ready), 32'd0);
    chk("reset load_done", 32'(load_done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_load(0, 1'b0, 1'b0, 1024, 1024, "full");

    port_op(4'b1010, 4'b1111, {8'h00, 8'h05, 8'h00, 8'hFF}, '0);
    chk("model s3[05]", ref_mem[2][8'h05], 32'h0000_0205);
    chk("model s1[FF]", ref_mem[0][8'hFF], 32'h0000_00FF);

    port_op(4'b0101, 4'b1101, {8'h10, 8'h00, 8'h10, 8'h00}, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0});
    port_op(4'b1101, 4'b1111, {8'h00, 8'h00, 8'h10, 8'h00}, '0);
    $display("concurrent write/read issued (write-readback=%0d)", WB);

    rand_ops(300);
    do_load(2, 1'b1, 1'b1, 1024, 2047, "stalled");
    rand_ops(200);

    do_load(0, 1'b0, 1'b0, 300, 0, "partial");
    #2 reset = 1'b1;
    #1;
    for (int b = 0; b < 4; b++) chk($sformatf("midload reset s%0d_out", b + 1), sout[b], 32'd0);
    chk("midload reset busy", 32'(busy), 32'd0);
    chk("midload reset load_ready", 32'(load_ready), 32'd0);
    chk("midload reset load_done", 32'(load_done), 32'd0);
    last_out = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    do_load(1, 1'b0, 1'b0, 1024, 1024, "reload");
    for (int a = 0; a < 256; a++) begin
      a8 = 8'(a);
      port_op(4'b0000, 4'b1111, {a8, a8, a8, a8}, '0);
    end
    for (int b = 0; b < 4; b++)
      chk($sformatf("model s%0d[7F]", b + 1), ref_mem[b][8'h7F], ~32'(b * 256 + 127));

    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sbox_sram.md
# sbox_sram

Responder-side S-box storage for the Blowfish/bcrypt key-schedule datapath. Holds the four 256x32 S-boxes as independent banks and serves the four active-low chip-select SRAM ports (`s1..s4`) driven by the key-expansion and Feistel initiators. A built-in load sequencer streams the 1024 initial S-box words (pi-digit constants) into the banks from an external word stream before any expansion starts.

## Interface

Parameters:
- `DEPTH`, 256: words per bank; address width is log2(DEPTH).
- `WIDTH`, 32: word width.

Ports:
- `clk` in 1: clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `sN_addr` in 8: bank N word address (N = 1..4).
- `sN_in` in 32: bank N write data.
- `sN_cs_l` in 1: bank N chip select, active low.
- `sN_we_l` in 1: bank N write enable, active low; meaningful only with `sN_cs_l`=0.
- `sN_out` out 32: bank N registered read data.
- `load_start` in 1: begin the initial-contents load.
- `load_valid` in 1: `load_data` holds a word.
- `load_data` in 32: initial-contents word stream.
- `load_ready` out 1: sequencer accepts a word this cycle.
- `load_done` out 1: one-cycle pulse, all 1024 words written.
- `busy` out 1: load in progress; initiator ports ignored.

## Operation

- Storage: four arrays `bank[1..4][0..255]`, 32 bits each. Array contents are not reset.
- Port access, state IDLE only, each bank independent and concurrent:
  - `cs_l`=0, `we_l`=1: read; `sN_out` <= `bank[N][addr]` at the edge.
  - `cs_l`=0, `we_l`=0: write; `bank[N][addr]` <= `sN_in`; `sN_out` holds (see Configuration).
  - `cs_l`=1: no access; `sN_out` holds its last value.
- Load sequencer FSM:
  - IDLE: `load_ready`=0, `busy`=0. On `load_start`=1 -> LOAD; word counter `cnt` (10 bits) <= 0.
  - LOAD: `load_ready`=1, `busy`=1. On `load_valid`=1, write `load_data` to bank `cnt[9:8]+1`, address `cnt[7:0]`, then `cnt` <= `cnt+1`. `load_valid`=0 stalls without penalty. The word accepted at `cnt`=1023 -> DONE.
  - DONE: `load_done`=1 and `busy`=0 for exactly one cycle -> IDLE.
- Word order: stream word k goes to S-box `k/256 + 1`, entry `k%256`, matching the Blowfish S-box constant order.
- During LOAD, all `sN_cs_l`/`sN_we_l` are ignored: no array writes from ports and `sN_out` holds.
- `load_start` is ignored outside IDLE. A second `load_start` in IDLE reloads from word 0.
- `cnt` wraps only through the DONE transition and never exceeds 1023.

## Timing

- Reset values: all `sN_out`=0, `load_ready`=0, `load_done`=0, `busy`=0; FSM in IDLE; `cnt`=0.
- Read latency is 1 cycle. Address is sampled at edge t and data is valid after edge t, stable until the next read or write-readback.
- Writes are visible to a read of the same address issued on the following cycle.
- Load timing:
  - `load_start` is sampled at edge t; `load_ready`/`busy` rise after edge t.
  - With `load_valid` held high, the 1024th word is accepted at edge t+1024 and `load_done` is high for cycle t+1024..t+1025.
  - Port accesses are honoured from the edge after `load_done`.
- `reset` asserted mid-load: the FSM returns to IDLE immediately and all outputs take their reset values. Partially written contents remain and a new `load_start` restarts at word 0.

## Configuration

- `SBOX_SRAM_WRITE_READBACK_EN`:
  - Defined: a port write also updates `sN_out` <= `sN_in` on the same edge (write-through). Initiators can chain a store into the next XOR without a re-read.
  - Undefined: `sN_out` holds across writes.
- The load sequencer never affects `sN_out` in either mode.

## Test plan

- Reset: assert `reset` mid-cycle -> all `sN_out`=0, `busy`=0, `load_ready`=0 asynchronously.
- Full load: `load_start` then 1024 continuous words with value k -> `load_done` pulses exactly 1024 cycles after `load_ready` rises. Reading s3 addr 0x05 then returns 0x00000205 and s1 addr 0xFF returns 0x000000FF one cycle after the request.
- Stalled load: drop `load_valid` every other cycle -> `load_done` after 2047 cycles. Port writes issued during LOAD leave the arrays unchanged and `sN_out` constant. A `load_start` pulsed during LOAD has no effect.
- Concurrent access: write 0xDEADBEEF to s2 addr 0x10 while reading s4 addr 0x10 in the same cycle, then read s2 addr 0x10.
  - s4 returns its loaded value.
  - s2 returns 0xDEADBEEF.
  - With the macro defined, s2 already shows 0xDEADBEEF after the write edge; without it, `s2_out` holds its prior value.
- Reset mid-load after 300 words, then a full reload of the complement (~k) -> all 1024 entries read back as ~k and `load_done` pulses once.
